demux_1to4_buf: RTL and testbench
=================================

Name: demux_1to4_buf

Overview:
Buffered 1-to-4 demultiplexer. It is the inverse of the datapath 4-to-1 selector: one 32-bit producer stream is steered by Sel to one of four consumer channels A/B/C/D.
Each channel has its own small FIFO with a valid/ready handshake, so a stalled consumer does not block words already queued for other channels.
It sits between the shared result bus and the per-destination write ports.

Parameters:
WIDTH, 32, data word width
DEPTH, 2, entries per channel FIFO; power of two, minimum 2

Ports:
Clk  in  1  rising-edge clock
Rst_n  in  1  asynchronous active-low reset
In_Valid  in  1  producer offers Din this cycle
In_Ready  out  1  block accepts Din this cycle
Sel  in  2  destination: 00=A, 01=B, 10=C, 11=D; qualified by In_Valid
Din  in  WIDTH  input word
Out_Valid  out  4  bit i set = channel i FIFO non-empty (bit0=A ... bit3=D)
Out_Ready  in  4  consumer i takes its head word this cycle
A  out  WIDTH  channel 0 head word
B  out  WIDTH  channel 1 head word
C  out  WIDTH  channel 2 head word
D  out  WIDTH  channel 3 head word
Busy  out  1  OR of Out_Valid

Behaviour:
- Clock and reset: one clock, Clk. Rst_n is asynchronous, active-low.
- Reset state: all FIFOs empty. Out_Valid=0000, Busy=0, A/B/C/D=0, every read/write pointer and occupancy count = 0. In_Ready=1 immediately after reset deasserts.
- Reset mid-operation: asserting Rst_n discards all queued words at once. Outputs return to the reset values asynchronously.
- Push: occurs when In_Valid & In_Ready. Din is written to the FIFO selected by Sel.
- In_Ready: combinationally equals ~full[Sel]. It depends only on the selected FIFO's full flag.
  - In_Ready never depends on Out_Ready. There is no combinational path from any consumer to the producer.
- Pop: channel i pops when Out_Valid[i] & Out_Ready[i]. All four channels may pop in the same cycle.
- Latency: a word pushed in cycle N appears at its channel output with Out_Valid high in cycle N+1, provided the FIFO was empty. Otherwise it appears after the words ahead of it.
- Output data: each output (A/B/C/D) is the FIFO head, read combinationally from storage at the read pointer.
  - While Out_Valid[i]=0, that output holds its last value. It is 0 after reset.
- Simultaneous push and pop on the same channel, not full: both take effect; occupancy is unchanged and the data order is preserved.
- Push to a full channel: refused (In_Ready=0), even if that channel pops in the same cycle. The producer retries the next cycle.
- Empty FIFO: Out_Ready is ignored; pointers and count are unchanged.
- Ordering: FIFO order within a channel. No ordering is guaranteed across channels.
- Pointers: log2(DEPTH) bits, wrapping modulo DEPTH. Occupancy count is log2(DEPTH)+1 bits. full = (count==DEPTH), empty = (count==0).
- Producer rule: Sel and Din must stay stable while In_Valid=1 and In_Ready=0. The bench checks this as a protocol assertion.
- No X-propagation: Din is stored only on a push.

Decomposition:
- Shared package (demux_pkg):
  - WIDTH_DEF=32, DEPTH_DEF=2
  - channel index constants CH_A=0, CH_B=1, CH_C=2, CH_D=3
  - 2-bit sel type
- Sub-module demux_chan_fifo (WIDTH, DEPTH):
  - ports Clk, Rst_n, Push, Pop, Wdata, Rdata, Full, Empty
  - instantiated four times
- The top level holds only the Sel decode, In_Ready mux, Out_Valid/Busy logic and output wiring.

Test Plan:
- Reset release, then Sel=00..11 in successive cycles with Din=1,2,3,4 and all Out_Ready=1 -> A=1, B=2, C=3, D=4. Each Out_Valid bit pulses for one cycle, one cycle after its push.
- Out_Ready=0000, push Din=5,6 to Sel=01, then offer Din=7 to Sel=01 -> In_Ready=0 on the third offer. Offering Din=8 to Sel=10 in the next cycle is accepted, so C=8.
- Channel B full (5,6); assert Out_Ready[1] for 2 cycles -> B=5 then 6, Out_Valid[1] falls, and In_Ready for Sel=01 returns to 1.
- Channel A holds 1 entry (9); push Din=10 to A while popping A in the same cycle -> A shows 9 then 10, and the count never exceeds 1.
- Push 11 to D and 12 to C, then pulse Rst_n low mid-cycle -> Out_Valid=0000, Busy=0 and all outputs=0 immediately. A post-reset push of Din=13 to D yields D=13.
- Random Sel/Din/Out_Ready for 10k cycles against a 4-queue scoreboard -> zero mismatches, and no push accepted while the selected channel is full.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared definitions for the buffered 1-to-4 demultiplexer.
package demux_pkg;

    localparam int unsigned WIDTH_DEF = 32;
    localparam int unsigned DEPTH_DEF = 2;
    localparam int unsigned NUM_CH    = 4;

    localparam int unsigned CH_A = 0;
    localparam int unsigned CH_B = 1;
    localparam int unsigned CH_C = 2;
    localparam int unsigned CH_D = 3;

    typedef logic [1:0] sel_t;

    // One-hot decode of a channel select.
    function automatic logic [NUM_CH-1:0] sel_decode(input sel_t sel);
        logic [NUM_CH-1:0] oh;
        oh      = '0;
        oh[sel] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/demux_chan_fifo.sv
// Per-channel FIFO with a hold register so the head output keeps its last
// value while the FIFO is empty.
module demux_chan_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Push,
    input  logic             Pop,
    input  logic [WIDTH-1:0] Wdata,
    output logic [WIDTH-1:0] Rdata,
    output logic             Full,
    output logic             Empty
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    logic [WIDTH-1:0] mem_q  [DEPTH];
    logic [WIDTH-1:0] mem_d  [DEPTH];
    logic [PtrW-1:0]  wptr_q, wptr_d;
    logic [PtrW-1:0]  rptr_q, rptr_d;
    logic [CntW-1:0]  cnt_q,  cnt_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             do_push;
    logic             do_pop;

    assign Full    = (cnt_q == CntW'(DEPTH));
    assign Empty   = (cnt_q == '0);
    // Guard locally so a push to a full FIFO or a pop of an empty one is a no-op.
    assign do_push = Push & ~Full;
    assign do_pop  = Pop & ~Empty;

    // Head word comes straight from storage; the last popped word is shown when empty.
    assign Rdata = Empty ? hold_q : mem_q[rptr_q];

    // Next-state for storage, pointers, occupancy and hold register.
    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        hold_d = hold_q;
        if (do_push) begin
            mem_d[wptr_q] = Wdata;
            wptr_d        = wptr_q + PtrW'(1);
        end
        if (do_pop) begin
            hold_d = mem_q[rptr_q];
            rptr_d = rptr_q + PtrW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // State registers; reset discards all queued words.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            hold_q <= '0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            hold_q <= hold_d;
        end
    end

endmodule

// File: rtl/demux_1to4_buf.sv
// Buffered 1-to-4 demultiplexer: steers one producer stream into four
// independently drained channel FIFOs.
module demux_1to4_buf
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  sel_t              Sel,
    input  logic [WIDTH-1:0]  Din,
    output logic [NUM_CH-1:0] Out_Valid,
    input  logic [NUM_CH-1:0] Out_Ready,
    output logic [WIDTH-1:0]  A,
    output logic [WIDTH-1:0]  B,
    output logic [WIDTH-1:0]  C,
    output logic [WIDTH-1:0]  D,
    output logic              Busy
);

    logic [NUM_CH-1:0] sel_oh;
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;
    logic [WIDTH-1:0]  rdata [NUM_CH];

    // Ready depends only on the selected FIFO, never on any consumer.
    always_comb begin
        sel_oh    = sel_decode(Sel);
        In_Ready  = ~full[Sel];
        push      = {NUM_CH{In_Valid & In_Ready}} & sel_oh;
        Out_Valid = ~empty;
        pop       = Out_Ready & Out_Valid;
        Busy      = |Out_Valid;
    end

    for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_chan
        demux_chan_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .Clk   (Clk),
            .Rst_n (Rst_n),
            .Push  (push[g]),
            .Pop   (pop[g]),
            .Wdata (Din),
            .Rdata (rdata[g]),
            .Full  (full[g]),
            .Empty (empty[g])
        );
    end

    assign A = rdata[CH_A];
    assign B = rdata[CH_B];
    assign C = rdata[CH_C];
    assign D = rdata[CH_D];

endmodule

// File: tb/tb_demux_1to4_buf.sv
// Testbench for demux_1to4_buf: directed scenarios plus a randomized run
// against a four-queue reference model.
module tb_demux_1to4_buf;
    import demux_pkg::*;

    localparam int unsigned W     = 32;
    localparam int unsigned DEPTH = 2;

    logic         Clk = 1'b0;
    logic         Rst_n = 1'b0;
    logic         In_Valid = 1'b0;
    logic         In_Ready;
    sel_t         Sel = 2'd0;
    logic [W-1:0] Din = '0;
    logic [3:0]   Out_Valid;
    logic [3:0]   Out_Ready = 4'b0;
    logic [W-1:0] A, B, C, D;
    logic         Busy;

    int checks   = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    demux_1to4_buf #(
        .WIDTH (W),
        .DEPTH (DEPTH)
    ) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .In_Valid  (In_Valid),
        .In_Ready  (In_Ready),
        .Sel       (Sel),
        .Din       (Din),
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready),
        .A         (A),
        .B         (B),
        .C         (C),
        .D         (D),
        .Busy      (Busy)
    );

    // Reference model: one queue per channel plus the last word taken from it.
    logic [W-1:0] mq [4][$];
    logic [W-1:0] mlast [4];

    logic         obs_ready, exp_ready;
    logic [3:0]   obs_valid, exp_valid;
    logic         obs_busy, exp_busy;
    logic [W-1:0] obs_data [4];
    logic [W-1:0] exp_data [4];

    // Producer stability check during stalls, enabled for the random run.
    bit           proto_en = 1'b0;
    logic         prev_stall = 1'b0;
    sel_t         prev_sel = 2'd0;
    logic [W-1:0] prev_din = '0;
    always @(posedge Clk) begin
        if (proto_en && prev_stall && In_Valid) begin
            assert (Sel == prev_sel && Din == prev_din)
            else $error("producer changed Sel/Din while stalled");
        end
        prev_stall <= In_Valid & ~In_Ready;
        prev_sel   <= Sel;
        prev_din   <= Din;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mq[i].delete();
            mlast[i] = '0;
        end
    endtask

    // Drive one cycle of inputs, sample outputs mid-cycle, predict, advance model.
    task automatic apply(input logic v, input sel_t s, input logic [W-1:0] d,
                         input logic [3:0] r);
        @(posedge Clk);
        #1;
        In_Valid  = v;
        Sel       = s;
        Din       = d;
        Out_Ready = r;
        @(negedge Clk);
        obs_ready   = In_Ready;
        obs_valid   = Out_Valid;
        obs_busy    = Busy;
        obs_data[0] = A;
        obs_data[1] = B;
        obs_data[2] = C;
        obs_data[3] = D;
        exp_ready = (mq[s].size() < int'(DEPTH));
        for (int i = 0; i < 4; i++) begin
            exp_valid[i] = (mq[i].size() != 0);
            exp_data[i]  = (mq[i].size() != 0) ? mq[i][0] : mlast[i];
        end
        exp_busy = |exp_valid;
        for (int i = 0; i < 4; i++) begin
            if (exp_valid[i] && r[i]) mlast[i] = mq[i].pop_front();
        end
        if (v && exp_ready) mq[s].push_back(d);
    endtask

    task automatic test_reset();
        Rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Rst_n = 1'b1;
        #1;
        checks++;
        if (Out_Valid !== 4'b0000) begin
            failures++;
            $display("FAIL reset_valid: got %b expected 0000", Out_Valid);
        end
        checks++;
        if (Busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy: got %b expected 0", Busy);
        end
        checks++;
        if ({A, B, C, D} !== {4*W{1'b0}}) begin
            failures++;
            $display("FAIL reset_data: got %h %h %h %h expected all 0", A, B, C, D);
        end
        checks++;
        if (In_Ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b expected 1", In_Ready);
        end
    endtask

    task automatic test_basic();
        logic [3:0]   ev [5];
        logic [W-1:0] ed [5];
        int           ch [5];
        ev = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        ed = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4};
        ch = '{0, 0, 1, 2, 3};
        for (int k = 0; k < 5; k++) begin
            if (k < 4) apply(1'b1, sel_t'(k), W'(k + 1), 4'b1111);
            else       apply(1'b0, 2'd0, '0, 4'b1111);
            checks++;
            if (obs_valid !== ev[k]) begin
                failures++;
                $display("FAIL basic_valid[%0d]: got %b expected %b", k, obs_valid, ev[k]);
            end
            if (k > 0) begin
                checks++;
                if (obs_data[ch[k]] !== ed[k]) begin
                    failures++;
                    $display("FAIL basic_data[%0d]: got %0h expected %0h", k,
                             obs_data[ch[k]], ed[k]);
                end
            end
        end
        apply(1'b0, 2'd0, '0, 4'b1111);
        checks++;
        if (obs_valid !== 4'b0000 || obs_busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_idle: got valid=%b busy=%b expected 0000/0",
                     obs_valid, obs_busy);
        end
        checks++;
        if (obs_data[3] !== 32'd4 || obs_data[0] !== 32'd1) begin
            failures++;
            $display("FAIL basic_hold: got D=%0h A=%0h expected 4/1", obs_data[3], obs_data[0]);
        end
    endtask

    task automatic test_full();
        logic exp_r [4];
        exp_r = '{1'b1, 1'b1, 1'b0, 1'b1};
        apply(1'b1, 2'd1, 32'd5, 4'b0000);
        checks++;
        if (obs_ready !== exp_r[0]) begin
            failures++;
            $display("FAIL full_ready0: got %b expected %b", obs_ready, exp_r[0]);
        end
        apply(1'b1, 2'd1, 32'd6, 4'b0000);
        checks++;
        if (obs_ready !== exp_r[1]) begin
            failures++;
            $display("FAIL full_ready1: got %b expected %b", obs_ready, exp_r[1]);
        end
        apply(1'b1, 2'd1, 32'd7, 4'b0000);
        checks++;
        if (obs_ready !== exp_r[2]) begin
            failures++;
            $display("FAIL full_refuse: got %b expected %b", obs_ready, exp_r[2]);
        end
        apply(1'b1, 2'd2, 32'd8, 4'b0000);
        checks++;
        if (obs_ready !== exp_r[3]) begin
            failures++;
            $display("FAIL full_other_chan: got %b expected %b", obs_ready, exp_r[3]);
        end
        apply(1'b0, 2'd1, '0, 4'b0000);
        checks++;
        if (obs_valid !== 4'b0110 || obs_data[2] !== 32'd8 || obs_data[1] !== 32'd5
            || obs_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_state: got valid=%b C=%0h B=%0h rdy=%b expected 0110/8/5/0",
                     obs_valid, obs_data[2], obs_data[1], obs_ready);
        end
    endtask

    task automatic test_drain();
        apply(1'b0, 2'd1, '0, 4'b0010);
        checks++;
        if (obs_data[1] !== 32'd5 || obs_valid[1] !== 1'b1) begin
            failures++;
            $display("FAIL drain_first: got B=%0h v=%b expected 5/1", obs_data[1], obs_valid[1]);
        end
        apply(1'b0, 2'd1, '0, 4'b0010);
        checks++;
        if (obs_data[1] !== 32'd6 || obs_ready !== 1'b1) begin
            failures++;
            $display("FAIL drain_second: got B=%0h rdy=%b expected 6/1", obs_data[1], obs_ready);
        end
        apply(1'b0, 2'd1, '0, 4'b0100);
        checks++;
        if (obs_valid !== 4'b0100 || obs_ready !== 1'b1 || obs_data[1] !== 32'd6) begin
            failures++;
            $display("FAIL drain_empty: got valid=%b rdy=%b B=%0h expected 0100/1/6",
                     obs_valid, obs_ready, obs_data[1]);
        end
        apply(1'b0, 2'd0, '0, 4'b0000);
        checks++;
        if (obs_valid !== 4'b0000) begin
            failures++;
            $display("FAIL drain_done: got %b expected 0000", obs_valid);
        end
    endtask

    task automatic test_simultaneous();
        apply(1'b1, 2'd0, 32'd9, 4'b0000);
        apply(1'b1, 2'd0, 32'd10, 4'b0001);
        checks++;
        if (obs_data[0] !== 32'd9 || obs_ready !== 1'b1) begin
            failures++;
            $display("FAIL simul_head: got A=%0h rdy=%b expected 9/1", obs_data[0], obs_ready);
        end
        apply(1'b0, 2'd0, '0, 4'b0001);
        checks++;
        if (obs_data[0] !== 32'd10 || obs_valid !== 4'b0001 || obs_ready !== 1'b1) begin
            failures++;
            $display("FAIL simul_next: got A=%0h valid=%b rdy=%b expected 10/0001/1",
                     obs_data[0], obs_valid, obs_ready);
        end
        apply(1'b0, 2'd0, '0, 4'b0000);
        checks++;
        if (obs_valid !== 4'b0000 || obs_data[0] !== 32'd10) begin
            failures++;
            $display("FAIL simul_end: got valid=%b A=%0h expected 0000/10",
                     obs_valid, obs_data[0]);
        end
    endtask

    task automatic test_async_reset();
        apply(1'b1, 2'd3, 32'd11, 4'b0000);
        apply(1'b1, 2'd2, 32'd12, 4'b0000);
        @(posedge Clk);
        #1;
        In_Valid  = 1'b0;
        Out_Ready = 4'b0000;
        checks++;
        if (Out_Valid !== 4'b1100) begin
            failures++;
            $display("FAIL arst_pre: got %b expected 1100", Out_Valid);
        end
        #2;
        Rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (Out_Valid !== 4'b0000 || Busy !== 1'b0) begin
            failures++;
            $display("FAIL arst_flags: got valid=%b busy=%b expected 0000/0", Out_Valid, Busy);
        end
        checks++;
        if ({A, B, C, D} !== {4*W{1'b0}}) begin
            failures++;
            $display("FAIL arst_data: got %h %h %h %h expected all 0", A, B, C, D);
        end
        @(negedge Clk);
        #1;
        Rst_n = 1'b1;
        apply(1'b1, 2'd3, 32'd13, 4'b0000);
        apply(1'b0, 2'd0, '0, 4'b0000);
        checks++;
        if (obs_valid !== 4'b1000 || obs_data[3] !== 32'd13) begin
            failures++;
            $display("FAIL arst_after: got valid=%b D=%0h expected 1000/13",
                     obs_valid, obs_data[3]);
        end
    endtask

    task automatic test_random();
        logic         hv = 1'b0;
        sel_t         hs = 2'd0;
        logic [W-1:0] hd = '0;
        bit           stalled = 1'b0;
        proto_en = 1'b1;
        for (int n = 0; n < 10000; n++) begin
            if (!stalled) begin
                hv = ($urandom_range(0, 3) != 0);
                hs = sel_t'($urandom_range(0, 3));
                hd = $urandom;
            end
            apply(hv, hs, hd, 4'($urandom));
            stalled = hv && !obs_ready;
            checks++;
            if (obs_ready !== exp_ready) begin
                failures++;
                if (failures < 20)
                    $display("FAIL rand_ready @%0d: got %b expected %b", n, obs_ready, exp_ready);
            end
            checks++;
            if (obs_valid !== exp_valid || obs_busy !== exp_busy) begin
                failures++;
                if (failures < 20)
                    $display("FAIL rand_valid @%0d: got %b/%b expected %b/%b", n,
                             obs_valid, obs_busy, exp_valid, exp_busy);
            end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (obs_data[i] !== exp_data[i]) begin
                    failures++;
                    if (failures < 20)
                        $display("FAIL rand_data%0d @%0d: got %0h expected %0h", i, n,
                                 obs_data[i], exp_data[i]);
                end
            end
        end
        apply(1'b0, 2'd0, '0, 4'b0000);
        proto_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_drain();
        test_simultaneous();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
